cpu_bus_mux: RTL



---
 rtl/cpu_bus_mux.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/cpu_bus_mux.sv
// CPU-to-core bus interconnect: prefix decode, IDLE/ACCESS/RESP sequencing, sticky error capture.
// Optional ready timeout enabled by defining CPU_BUS_MUX_TIMEOUT_EN.
module cpu_bus_mux #(
  parameter int                          NUM_SLAVES     = 8,
  parameter logic [8*NUM_SLAVES-1:0]     SLAVE_PREFIXES = {NUM_SLAVES{8'h00}},
  parameter int                          TIMEOUT_CYCLES = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cpu_valid,
  input  logic [31:0]                cpu_addr,
  input  logic [3:0]                 cpu_wstrb,
  input  logic [31:0]                cpu_wdata,
  output logic                       cpu_ready,
  output logic [31:0]                cpu_rdata,
  output logic [NUM_SLAVES-1:0]      slv_cs,
  output logic [3:0]                 slv_we,
  output logic [21:0]                slv_address,
  output logic [31:0]                slv_write_data,
  input  logic [32*NUM_SLAVES-1:0]   slv_read_data,
  input  logic [NUM_SLAVES-1:0]      slv_ready,
  output logic                       err,
  input  logic                       err_clr,
  output logic [31:0]                err_addr
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                  state_q, state_d;
  logic [NUM_SLAVES-1:0]   match, grant;
  logic [NUM_SLAVES-1:0]   slv_cs_q, slv_cs_d;
  logic [31:0]             addr_q, addr_d;
  logic [3:0]              we_q, we_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [31:0]             rdata_q, rdata_d;
  logic                    ready_q, ready_d;
  logic                    err_q, err_d;
  logic [31:0]             err_addr_q, err_addr_d;
  logic                    err_set;
  logic [31:0]             err_set_addr;
  logic                    sel_ready;
  logic [31:0]             sel_rdata;

`ifdef CPU_BUS_MUX_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0]             tmo_cnt_q, tmo_cnt_d;
`endif

  if (NUM_SLAVES < 1 || NUM_SLAVES > 16 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_params
    $error("cpu_bus_mux: NUM_SLAVES or TIMEOUT_CYCLES out of range");
  end

  for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_match
    assign match[gi] = (cpu_addr[31:24] == SLAVE_PREFIXES[8*gi +: 8]);
  end

  // Scanning downward leaves the lowest matching index as the winner.
  always_comb begin
    grant = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (match[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
      end
    end
  end

  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (slv_cs_q[i]) sel_rdata = sel_rdata | slv_read_data[32*i +: 32];
    end
  end

  assign sel_ready = |(slv_ready & slv_cs_q);

  always_comb begin
    state_d      = state_q;
    slv_cs_d     = slv_cs_q;
    addr_d       = addr_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    ready_d      = 1'b0;
    err_set      = 1'b0;
    err_set_addr = addr_q;
`ifdef CPU_BUS_MUX_TIMEOUT_EN
    tmo_cnt_d    = tmo_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (cpu_valid) begin
          addr_d  = cpu_addr;
          we_d    = cpu_wstrb;
          wdata_d = cpu_wdata;
`ifdef CPU_BUS_MUX_TIMEOUT_EN
          tmo_cnt_d = '0;
`endif
          if (|match) begin
            slv_cs_d = grant;
            state_d  = ACCESS;
          end else begin
            rdata_d      = '0;
            ready_d      = 1'b1;
            err_set      = 1'b1;
            err_set_addr = cpu_addr;
            state_d      = RESP;
          end
        end
      end
      ACCESS: begin
        // Ready takes priority over an expiring timeout in the same cycle.
        if (sel_ready) begin
          rdata_d  = sel_rdata;
          slv_cs_d = '0;
          ready_d  = 1'b1;
          state_d  = RESP;
        end
`ifdef CPU_BUS_MUX_TIMEOUT_EN
        else if (tmo_cnt_q == TMO_LAST) begin
          rdata_d  = 32'hdeadbeef;
          slv_cs_d = '0;
          ready_d  = 1'b1;
          err_set  = 1'b1;
          state_d  = RESP;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 16'd1;
        end
`endif
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        slv_cs_d = '0;
        state_d  = IDLE;
      end
    endcase
  end

  // A new error during a clear still records its address; otherwise the first error is kept.
  always_comb begin
    err_d      = err_q;
    err_addr_d = err_addr_q;
    if (err_clr) begin
      err_d      = 1'b0;
      err_addr_d = '0;
    end
    if (err_set) begin
      err_d = 1'b1;
      if (!err_q || err_clr) err_addr_d = err_set_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      slv_cs_q   <= '0;
      addr_q     <= '0;
      we_q       <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      ready_q    <= 1'b0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
`ifdef CPU_BUS_MUX_TIMEOUT_EN
      tmo_cnt_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      slv_cs_q   <= slv_cs_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      ready_q    <= ready_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
`ifdef CPU_BUS_MUX_TIMEOUT_EN
      tmo_cnt_q  <= tmo_cnt_d;
`endif
    end
  end

  assign cpu_ready      = ready_q;
  assign cpu_rdata      = rdata_q;
  assign slv_cs         = slv_cs_q;
  assign slv_we         = we_q;
  assign slv_address    = addr_q[23:2];
  assign slv_write_data = wdata_q;
  assign err            = err_q;
  assign err_addr       = err_addr_q;

endmodule
